mem_access_ctrl: RTL and testbench

- Sequencer and arbiter in front of the 32-bit byte-banked on-chip memory. The memory is single-ported per direction and its write enable covers all 4 bytes.
- Shares the memory between the instruction-fetch port (read-only) and the data port (load/store).
- Issues word-aligned addresses only.
- Performs read-modify-write for byte and halfword stores.
- Extracts and sign- or zero-extends byte and halfword loads.

---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_lane_fmt.sv | 44 ++++
 rtl/mem_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the on-chip memory access sequencer.
// Encodings are fixed so the exported debug state reads directly as a 2-bit code.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        RESP    = 2'd3
    } stateT;

    typedef enum logic {
        G_I = 1'b0,
        G_D = 1'b1
    } granteeT;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic [63:0] alignAddr(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: extracts/extends sub-word loads and merges sub-word
// store data into a full memory word. Purely combinational.
module mem_lane_fmt
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    input  logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic [31:0] mergedData
);

    logic [4:0]  shamt;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] mask;

    assign shamt = {lane, 3'b000};

    always_comb begin
        byteVal = 8'(word >> shamt);
        halfVal = 16'(word >> shamt);
        loadData = word;
        mask = 32'hFFFF_FFFF;
        case (size)
            SZ_B: begin
                loadData = {{24{~isUnsigned & byteVal[7]}}, byteVal};
                mask = 32'h0000_00FF << shamt;
            end
            SZ_H: begin
                loadData = {{16{~isUnsigned & halfVal[15]}}, halfVal};
                mask = 32'h0000_FFFF << shamt;
            end
            default: begin
                loadData = word;
                mask = 32'hFFFF_FFFF;
            end
        endcase
        mergedData = (word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch and data ports onto the word-wide memory, sequencing
// read-modify-write for sub-word stores and formatting sub-word loads.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int D_MAX      = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        IReq,
    input  logic [63:0] IAddr,
    output logic        IAck,
    output logic [31:0] IData,
    output logic        IErr,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [1:0]  DSize,
    input  logic        DUnsigned,
    input  logic [63:0] DAddr,
    input  logic [31:0] DWdata,
    output logic        DAck,
    output logic [31:0] DRdata,
    output logic        DErr,
    output logic [63:0] MemRAddr,
    output logic [63:0] MemWAddr,
    output logic [31:0] MemWdata,
    output logic        MemWr,
    input  logic [31:0] MemRdata,
    output logic [1:0]  DbgState
);

    localparam int              CW       = $clog2(D_MAX + 1);
    localparam logic [CW-1:0]   D_MAX_C  = CW'(D_MAX);
    localparam logic [1:0]      LAT_LOAD = 2'(MEM_RD_LAT - 1);

    // Handshake: a requester raises Req with stable operands and holds them
    // until its one-cycle Ack; Ack, data and Err are valid only together.

    stateT         state, stateNext;
    granteeT       gnt;
    logic          opWe, opUns;
    logic [1:0]    opSize, opLane;
    logic [31:0]   opWdata;
    logic [CW-1:0] grantCnt;
    logic [1:0]    latCnt;
    logic          grantD, grantI, reqErr, capture;
    logic          fetchErr, dataErr;
    logic [31:0]   loadData, mergedData;

    assign DbgState = state;

    assign fetchErr = IAddr[1:0] != 2'b00;
    assign dataErr  = (DSize == 2'b11)
                    | ((DSize == SZ_H) & DAddr[0])
                    | ((DSize == SZ_W) & (DAddr[1:0] != 2'b00));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        grantD    = 1'b0;
        grantI    = 1'b0;
        reqErr    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless fetch has been starved for D_MAX grants.
                grantD = DReq & ~(IReq & (grantCnt == D_MAX_C));
                grantI = IReq & ~grantD;
                if (grantD || grantI) begin
                    reqErr = grantD ? dataErr : fetchErr;
                    if (reqErr)                                  stateNext = RESP;
                    else if (grantD && DWe && (DSize == SZ_W))   stateNext = WRITE;
                    else                                         stateNext = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (latCnt == 2'd0) begin
                    capture   = 1'b1;
                    stateNext = opWe ? WRITE : RESP;
                end
            end
            WRITE:   stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    mem_lane_fmt laneFmt (
        .word       (MemRdata),
        .lane       (opLane),
        .size       (opSize),
        .isUnsigned (opUns),
        .wdata      (opWdata),
        .loadData   (loadData),
        .mergedData (mergedData)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gnt      <= G_I;
            opWe     <= 1'b0;
            opUns    <= 1'b0;
            opSize   <= 2'b00;
            opLane   <= 2'b00;
            opWdata  <= 32'd0;
            grantCnt <= '0;
            latCnt   <= 2'd0;
            IAck     <= 1'b0;
            IData    <= 32'd0;
            IErr     <= 1'b0;
            DAck     <= 1'b0;
            DRdata   <= 32'd0;
            DErr     <= 1'b0;
            MemRAddr <= 64'd0;
            MemWAddr <= 64'd0;
            MemWdata <= 32'd0;
            MemWr    <= 1'b0;
        end else begin
            IAck   <= 1'b0;
            IData  <= 32'd0;
            IErr   <= 1'b0;
            DAck   <= 1'b0;
            DRdata <= 32'd0;
            DErr   <= 1'b0;
            MemWr  <= 1'b0;

            if (grantD || grantI) begin
                gnt      <= grantD ? G_D : G_I;
                opWe     <= grantD & DWe;
                opSize   <= grantD ? DSize : SZ_W;
                opUns    <= DUnsigned;
                opLane   <= grantD ? DAddr[1:0] : IAddr[1:0];
                opWdata  <= DWdata;
                latCnt   <= LAT_LOAD;
                grantCnt <= (grantD && IReq) ? grantCnt + 1'b1 : '0;
                if (reqErr) begin
                    if (grantD) begin
                        DAck <= 1'b1;
                        DErr <= 1'b1;
                    end else begin
                        IAck <= 1'b1;
                        IErr <= 1'b1;
                    end
                end else if (stateNext == WRITE) begin
                    MemWr    <= 1'b1;
                    MemWAddr <= alignAddr(DAddr);
                    MemWdata <= DWdata;
                end else begin
                    MemRAddr <= alignAddr(grantD ? DAddr : IAddr);
                    if (grantD && DWe) MemWAddr <= alignAddr(DAddr);
                end
            end

            if (state == RD_WAIT) begin
                if (!capture) begin
                    latCnt <= latCnt - 1'b1;
                end else if (opWe) begin
                    MemWr    <= 1'b1;
                    MemWdata <= mergedData;
                end else if (gnt == G_D) begin
                    DAck   <= 1'b1;
                    DRdata <= loadData;
                end else begin
                    IAck  <= 1'b1;
                    IData <= MemRdata;
                end
            end

            if (state == WRITE) DAck <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: two instances (read latency 1 and 3)
// share one memory model; a byte-level reference model predicts acks and writes.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n, Reset3_n;
    logic        IReq, DReq, DWe, DUnsigned;
    logic [63:0] IAddr, DAddr;
    logic [1:0]  DSize;
    logic [31:0] DWdata;

    logic        IAck, IErr, DAck, DErr, MemWr;
    logic [31:0] IData, DRdata, MemWdata, MemRdata;
    logic [63:0] MemRAddr, MemWAddr;
    logic [1:0]  DbgState;

    logic        IAck3, IErr3, DAck3, DErr3, MemWr3;
    logic [31:0] IData3, DRdata3, MemWdata3, MemRdata3;
    logic [63:0] MemRAddr3, MemWAddr3;
    logic [1:0]  DbgState3;

    logic        activeDut = 1'b0;
    logic [31:0] cycleNow = 32'd0;
    int          nChecks = 0;
    int          nErrors = 0;

    logic [49:0]  expQ[$];
    logic [111:0] expWrQ[$];

    logic [31:0] mem [0:255];
    logic        memReady = 1'b0;
    logic [7:0]  rdA1, rdA2;
    logic [7:0]  refB [0:1023];

    mem_access_ctrl #(.MEM_RD_LAT(1), .D_MAX(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IData(IData), .IErr(IErr),
        .DReq(DReq), .DWe(DWe), .DSize(DSize), .DUnsigned(DUnsigned),
        .DAddr(DAddr), .DWdata(DWdata), .DAck(DAck), .DRdata(DRdata), .DErr(DErr),
        .MemRAddr(MemRAddr), .MemWAddr(MemWAddr), .MemWdata(MemWdata),
        .MemWr(MemWr), .MemRdata(MemRdata), .DbgState(DbgState)
    );

    mem_access_ctrl #(.MEM_RD_LAT(3), .D_MAX(4)) dut3 (
        .Clk(Clk), .Reset_n(Reset3_n),
        .IReq(IReq), .IAddr(IAddr), .IAck(IAck3), .IData(IData3), .IErr(IErr3),
        .DReq(DReq), .DWe(DWe), .DSize(DSize), .DUnsigned(DUnsigned),
        .DAddr(DAddr), .DWdata(DWdata), .DAck(DAck3), .DRdata(DRdata3), .DErr(DErr3),
        .MemRAddr(MemRAddr3), .MemWAddr(MemWAddr3), .MemWdata(MemWdata3),
        .MemWr(MemWr3), .MemRdata(MemRdata3), .DbgState(DbgState3)
    );

    // Clock and memory model: latency 1 reads the registered address directly,
    // latency 3 delays the address by two more cycles.
    always #5 Clk = ~Clk;

    always @(posedge Clk) cycleNow <= cycleNow + 32'd1;

    function automatic logic [31:0] initWord(input int i);
        return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_5A5A;
    endfunction

    always @(posedge Clk) begin
        if (!memReady) begin
            for (int i = 0; i < 256; i++) mem[i] <= initWord(i);
            memReady <= 1'b1;
        end else begin
            if (MemWr)  mem[MemWAddr[9:2]]  <= MemWdata;
            if (MemWr3) mem[MemWAddr3[9:2]] <= MemWdata3;
        end
        rdA1 <= MemRAddr3[9:2];
        rdA2 <= rdA1;
    end

    assign MemRdata  = mem[MemRAddr[9:2]];
    assign MemRdata3 = mem[rdA2];

    logic        monIAck, monDAck, monIErr, monDErr, monMemWr;
    logic [31:0] monIData, monDRdata, monMemWdata;
    logic [63:0] monMemWAddr;
    assign monIAck     = activeDut ? IAck3     : IAck;
    assign monDAck     = activeDut ? DAck3     : DAck;
    assign monIErr     = activeDut ? IErr3     : IErr;
    assign monDErr     = activeDut ? DErr3     : DErr;
    assign monIData    = activeDut ? IData3    : IData;
    assign monDRdata   = activeDut ? DRdata3   : DRdata;
    assign monMemWr    = activeDut ? MemWr3    : MemWr;
    assign monMemWAddr = activeDut ? MemWAddr3 : MemWAddr;
    assign monMemWdata = activeDut ? MemWdata3 : MemWdata;

    task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cycleNow);
        end
    endtask

    // Scoreboard: ack entries {isD, err, data, ackCycle}; write entries {cycle, addr, data}.
    always @(negedge Clk) begin
        logic [49:0]  e;
        logic [111:0] w;
        if (monIAck || monDAck) begin
            if (expQ.size() == 0) begin
                checkVal("ack_unexpected", {62'd0, monDAck, monIAck}, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkVal("ack_port",  64'(monDAck), 64'(e[49]));
                checkVal("ack_cycle", 64'(cycleNow[15:0]), 64'(e[15:0]));
                checkVal("ack_err",   64'(monDAck ? monDErr : monIErr), 64'(e[48]));
                checkVal("ack_data",  64'(monDAck ? monDRdata : monIData), 64'(e[47:16]));
            end
        end
        if (monMemWr) begin
            if (expWrQ.size() == 0) begin
                checkVal("memwr_unexpected", 64'(monMemWr), 64'd0);
            end else begin
                w = expWrQ.pop_front();
                checkVal("wr_cycle", 64'(cycleNow[15:0]), 64'(w[111:96]));
                checkVal("wr_addr",  monMemWAddr, w[95:32]);
                checkVal("wr_data",  64'(monMemWdata), 64'(w[31:0]));
            end
        end
    end

    function automatic logic [31:0] refWord(input logic [63:0] addr);
        int a;
        a = int'({addr[9:2], 2'b00});
        return {refB[a+3], refB[a+2], refB[a+1], refB[a]};
    endfunction

    function automatic logic [31:0] refLoad(input logic [63:0] addr, input logic [1:0] size, input logic uns);
        int a;
        logic [7:0] b0, b1;
        a  = int'(addr[9:0]);
        b0 = refB[a];
        b1 = refB[a+1];
        if (size == 2'b00) return {{24{~uns & b0[7]}}, b0};
        if (size == 2'b01) return {{16{~uns & b1[7]}}, b1, b0};
        return {refB[a+3], refB[a+2], b1, b0};
    endfunction

    task automatic refStore(input logic [63:0] addr, input logic [1:0] size, input logic [31:0] wd);
        int a;
        a = int'(addr[9:0]);
        refB[a] = wd[7:0];
        if (size != 2'b00) refB[a+1] = wd[15:8];
        if (size == 2'b10) begin
            refB[a+2] = wd[23:16];
            refB[a+3] = wd[31:24];
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) begin
            checkVal("drain_timeout", 64'(expQ.size()), 64'd0);
            expQ.delete();
        end
    endtask

    task automatic issueData(input logic we, input logic [1:0] size, input logic uns,
                             input logic [63:0] addr, input logic [31:0] wdata);
        logic err;
        int lat, curLat;
        logic [31:0] expD, w;
        curLat = activeDut ? 3 : 1;
        err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        lat = err ? 1 : (we ? ((size == 2'b10) ? 2 : curLat + 2) : curLat + 1);
        expD = 32'd0;
        w = 32'd0;
        if (!err && !we) expD = refLoad(addr, size, uns);
        if (!err && we) begin
            refStore(addr, size, wdata);
            w = refWord(addr);
        end
        @(negedge Clk);
        if (we && !err) expWrQ.push_back({16'(cycleNow + 32'(lat - 1)), {addr[63:2], 2'b00}, w});
        expQ.push_back({1'b1, err, expD, 16'(cycleNow + 32'(lat))});
        DReq = 1'b1; DWe = we; DSize = size; DUnsigned = uns; DAddr = addr; DWdata = wdata;
        waitDrain();
        DReq = 1'b0;
    endtask

    task automatic issueFetch(input logic [63:0] addr);
        logic err;
        int lat;
        err = addr[1:0] != 2'b00;
        lat = err ? 1 : (activeDut ? 4 : 2);
        @(negedge Clk);
        expQ.push_back({1'b0, err, err ? 32'd0 : refWord(addr), 16'(cycleNow + 32'(lat))});
        IReq = 1'b1; IAddr = addr;
        waitDrain();
        IReq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] base, dW, iW, w;
        logic [1:0]  sz, ln;
        logic [63:0] addr;
        for (int i = 0; i < 256; i++) begin
            w = initWord(i);
            for (int k = 0; k < 4; k++) refB[4*i+k] = w[8*k +: 8];
        end
        Reset_n = 1'b0; Reset3_n = 1'b0;
        IReq = 1'b0; IAddr = 64'd0; DReq = 1'b0; DWe = 1'b0; DSize = 2'b00;
        DUnsigned = 1'b0; DAddr = 64'd0; DWdata = 32'd0;

        repeat (3) @(negedge Clk);
        #1;
        checkVal("rst_iack",     64'(IAck), 64'd0);
        checkVal("rst_dack",     64'(DAck), 64'd0);
        checkVal("rst_memwr",    64'(MemWr), 64'd0);
        checkVal("rst_raddr",    MemRAddr, 64'd0);
        checkVal("rst_waddr",    MemWAddr, 64'd0);
        checkVal("rst_wdata",    64'(MemWdata), 64'd0);
        checkVal("rst_idata",    64'(IData), 64'd0);
        checkVal("rst_drdata",   64'(DRdata), 64'd0);
        checkVal("rst_state",    64'(DbgState), 64'(IDLE));
        Reset_n = 1'b1;
        @(negedge Clk);

        // Word store/load, then sub-word store and formatted loads.
        issueData(1'b1, SZ_W, 1'b0, 64'h100, 32'hDEADBEEF);
        issueData(1'b0, SZ_W, 1'b0, 64'h100, 32'd0);
        issueData(1'b1, SZ_B, 1'b0, 64'h101, 32'h0000_0055);
        issueData(1'b0, SZ_B, 1'b0, 64'h101, 32'd0);
        issueData(1'b0, SZ_B, 1'b0, 64'h103, 32'd0);
        issueData(1'b0, SZ_B, 1'b1, 64'h103, 32'd0);
        issueData(1'b0, SZ_H, 1'b0, 64'h102, 32'd0);
        issueData(1'b0, SZ_H, 1'b1, 64'h102, 32'd0);
        issueData(1'b0, SZ_W, 1'b0, 64'h100, 32'd0);
        checkVal("sb_merge_word", 64'(refWord(64'h100)), 64'hDEAD55EF);

        // Both ports held: four data grants then a forced fetch, repeating.
        @(negedge Clk);
        base = cycleNow;
        dW = refWord(64'h100);
        iW = refWord(64'h000);
        for (int k = 0; k < 10; k++)
            expQ.push_back({(k % 5) != 4, 1'b0, ((k % 5) != 4) ? dW : iW, 16'(base + 32'(2 + 3*k))});
        DReq = 1'b1; DWe = 1'b0; DSize = SZ_W; DUnsigned = 1'b0; DAddr = 64'h100;
        IReq = 1'b1; IAddr = 64'h000;
        waitDrain();
        DReq = 1'b0; IReq = 1'b0;
        issueFetch(64'h008);

        // Misaligned and illegal accesses never touch memory.
        issueData(1'b0, SZ_W, 1'b0, 64'h102, 32'd0);
        issueData(1'b1, SZ_H, 1'b0, 64'h101, 32'h1234);
        issueFetch(64'h006);
        issueData(1'b0, 2'b11, 1'b0, 64'h100, 32'd0);
        issueData(1'b1, 2'b11, 1'b0, 64'h104, 32'hCAFE_F00D);

        for (int n = 0; n < 12; n++) begin
            sz = 2'($urandom_range(0, 2));
            ln = (sz == SZ_B) ? 2'($urandom_range(0, 3)) : (sz == SZ_H) ? 2'(2 * $urandom_range(0, 1)) : 2'b00;
            addr = 64'h100 + 64'(4 * $urandom_range(0, 3)) + 64'(ln);
            issueData(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom);
        end

        // Reset during the write cycle of a byte store.
        issueData(1'b1, SZ_W, 1'b0, 64'h100, 32'hDEADBEEF);
        @(negedge Clk);
        base = cycleNow;
        w = refWord(64'h100);
        w[15:8] = 8'h77;
        expWrQ.push_back({16'(base + 32'd2), 64'h100, w});
        DReq = 1'b1; DWe = 1'b1; DSize = SZ_B; DUnsigned = 1'b0; DAddr = 64'h101; DWdata = 32'h77;
        @(negedge Clk);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        checkVal("rst_mid_memwr", 64'(MemWr), 64'd0);
        checkVal("rst_mid_state", 64'(DbgState), 64'(IDLE));
        DReq = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        #1;
        checkVal("post_rst_state", 64'(DbgState), 64'(IDLE));
        issueData(1'b0, SZ_W, 1'b0, 64'h100, 32'd0);

        // Read latency 3 instance.
        @(negedge Clk);
        Reset_n = 1'b0;
        activeDut = 1'b1;
        Reset3_n = 1'b1;
        @(negedge Clk);
        issueData(1'b0, SZ_W, 1'b0, 64'h100, 32'd0);
        issueData(1'b1, SZ_B, 1'b0, 64'h102, 32'h0000_00A5);
        issueData(1'b0, SZ_B, 1'b0, 64'h102, 32'd0);
        issueData(1'b0, SZ_H, 1'b1, 64'h102, 32'd0);
        issueFetch(64'h100);
        issueData(1'b1, SZ_W, 1'b0, 64'h10C, 32'h0BAD_CAFE);
        issueData(1'b0, SZ_W, 1'b0, 64'h10C, 32'd0);
        issueData(1'b0, SZ_H, 1'b0, 64'h103, 32'd0);

        repeat (3) @(negedge Clk);
        #1;
        checkVal("leftover_acks",   64'(expQ.size()), 64'd0);
        checkVal("leftover_writes", 64'(expWrQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
